// File: rtl/comparador_serial_if.sv
// Bundles the operand/handshake side of the serial magnitude comparator.
// Latency: none, wires only.
// Backpressure: none. The requester waits for done before issuing another start, except in the done cycle itself.
// Ports (master = requester, slave = comparator):
//   start, signed_mode, A, B       requester -> comparator
//   busy, done, P, Q, mayor, menor, igual   comparator -> requester
interface comparador_serial_if #(
    parameter int N = 8
) ();
    logic         start;
    logic         signed_mode;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         P;
    logic         Q;
    logic         mayor;
    logic         menor;
    logic         igual;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, P, Q, mayor, menor, igual
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, P, Q, mayor, menor, igual
    );
endinterface

// File: rtl/comparador_serial.sv
// Compares two N-bit words MSB first, K bits per clock, using the iterative-network cell rule (PQ state).
// Latency: N/K cycles from the start edge to done, or fewer when EARLY_EXIT stops at the first difference.
// Backpressure: start is only taken in IDLE or DONE and is ignored while busy.
// Ports: clk, reset (sync, active high); bus.slave carries start/signed_mode/A/B in and
//        busy/done/P/Q/mayor/menor/igual out.
module comparador_serial #(
    parameter int N          = 8,
    parameter int K          = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    comparador_serial_if.slave  bus
);
    localparam int M  = N / K;
    localparam int GW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic           sgn_q;
    logic [1:0]     pq_q;
    logic [1:0]     pq_eval;
    logic [GW-1:0]  g_q;
    logic           mayor_q;
    logic           menor_q;
    logic           igual_q;
    logic           accept;
    logic           last_grp;
    logic           finish;

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_grp = (g_q == GW'(M - 1));
    assign finish   = last_grp || ((EARLY_EXIT != 0) && (pq_eval != 2'b01));

    // Operands are shifted left once per group, so the current group always
    // sits in the top K bits. The sign bit is the very first bit of group 0,
    // where signed mode swaps the two transitions.
    always_comb begin
        pq_eval = pq_q;
        for (int i = 0; i < K; i++) begin
            if ((pq_eval == 2'b01) && (a_sh[N-1-i] != b_sh[N-1-i])) begin
                if (sgn_q && (g_q == '0) && (i == 0)) begin
                    pq_eval = a_sh[N-1-i] ? 2'b11 : 2'b10;
                end else begin
                    pq_eval = a_sh[N-1-i] ? 2'b10 : 2'b11;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = finish ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, group evaluation, result load on entry to DONE.
    // Results are deliberately left alone on accept so they stay readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sgn_q   <= 1'b0;
            pq_q    <= 2'b01;
            g_q     <= '0;
            mayor_q <= 1'b0;
            menor_q <= 1'b0;
            igual_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            sgn_q <= bus.signed_mode;
            pq_q  <= 2'b01;
            g_q   <= '0;
        end else if (state_q == RUN) begin
            pq_q <= pq_eval;
            a_sh <= a_sh << K;
            b_sh <= b_sh << K;
            g_q  <= g_q + GW'(1);
            if (finish) begin
                igual_q <= (pq_eval == 2'b01);
                mayor_q <= (pq_eval == 2'b10);
                menor_q <= (pq_eval == 2'b11);
            end
        end
    end

    // Output logic
    always_comb begin
        bus.busy  = (state_q == RUN);
        bus.done  = (state_q == DONE);
        bus.P     = pq_q[1];
        bus.Q     = pq_q[0];
        bus.mayor = mayor_q;
        bus.menor = menor_q;
        bus.igual = igual_q;
    end
endmodule
